// File: rtl/detect_channel_scheduler.sv
// detect_channel_scheduler: one shared pattern-match engine, time-multiplexed
// across NCH serial channels. A round-robin arbiter picks one requesting
// channel per cycle; that channel's saved bit history and fill count are
// evaluated against PATTERN and written back. Per-channel saturating hit
// counters are readable through rd_sel/rd_cnt.
module detect_channel_scheduler #(
  parameter int              NCH     = 4,
  parameter int              PLEN    = 4,
  parameter logic [PLEN-1:0] PATTERN = 4'b1101,
  parameter int              CNT_W   = 8
) (
  input  logic                     CP,
  input  logic                     RST,
  input  logic                     en,
  input  logic [NCH-1:0]           req,
  input  logic [NCH-1:0]           din,
  output logic [NCH-1:0]           gnt,
  output logic                     hit_valid,
  output logic [$clog2(NCH)-1:0]   hit_ch,
  input  logic                     clr,
  input  logic [$clog2(NCH)-1:0]   clr_sel,
  input  logic [$clog2(NCH)-1:0]   rd_sel,
  output logic [CNT_W-1:0]         rd_cnt
);

  localparam int SW = $clog2(NCH);
  localparam int FW = $clog2(PLEN);
  localparam logic [FW-1:0] FILL_MAX = FW'(PLEN - 1);

  // saved per-channel context
  logic [PLEN-2:0]  hist [NCH];
  logic [FW-1:0]    fill [NCH];
  logic [CNT_W-1:0] cnt  [NCH];

  // index of the most recently served channel; search starts just above it
  logic [SW-1:0]    ptr;

  logic [NCH-1:0]   clr_mask;
  logic [NCH-1:0]   elig;
  logic [SW-1:0]    cand;
  logic [SW-1:0]    gnt_idx;
  logic             consume;
  logic             gnt_bit;
  logic [PLEN-1:0]  window;
  logic             match;

  // a channel being cleared this edge is withheld so the clear is never lost
  always_comb begin
    clr_mask = '0;
    for (int i = 0; i < NCH; i++) begin
      if (clr && (SW'(i) == clr_sel)) clr_mask[i] = 1'b1;
    end
  end

  // round-robin search from ptr+1 upward, wrapping; first eligible requester wins
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    consume = 1'b0;
    cand    = '0;
    elig    = req & ~clr_mask;
    if (en && !RST) begin
      for (int k = 1; k <= NCH; k++) begin
        cand = SW'((int'(ptr) + k) % NCH);
        if (!consume && elig[cand]) begin
          consume = 1'b1;
          gnt_idx = cand;
        end
      end
    end
    if (consume) gnt[gnt_idx] = 1'b1;
  end

  // evaluate the granted channel's history extended by its new bit
  always_comb begin
    gnt_bit = din[gnt_idx];
    window  = {hist[gnt_idx], gnt_bit};
    match   = consume && (fill[gnt_idx] == FILL_MAX) && (window == PATTERN);
  end

  // context write-back, hit counting and channel clear
  always_ff @(posedge CP or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NCH; i++) begin
        hist[i] <= '0;
        fill[i] <= '0;
        cnt[i]  <= '0;
      end
    end else begin
      if (consume) begin
        hist[gnt_idx] <= window[PLEN-2:0];
        if (fill[gnt_idx] != FILL_MAX) fill[gnt_idx] <= fill[gnt_idx] + 1'b1;
        if (match && (cnt[gnt_idx] != '1)) cnt[gnt_idx] <= cnt[gnt_idx] + 1'b1;
      end
      if (clr) begin
        hist[clr_sel] <= '0;
        fill[clr_sel] <= '0;
        cnt[clr_sel]  <= '0;
      end
    end
  end

  // arbiter pointer and registered hit report
  always_ff @(posedge CP or posedge RST) begin
    if (RST) begin
      ptr       <= SW'(NCH - 1);
      hit_valid <= 1'b0;
      hit_ch    <= '0;
    end else begin
      hit_valid <= match;
      if (match) hit_ch <= gnt_idx;
      if (consume) ptr <= gnt_idx;
    end
  end

  assign rd_cnt = cnt[rd_sel];

endmodule

// File: tb/tb_detect_channel_scheduler.sv
// Testbench for detect_channel_scheduler: table-driven vectors, hand-written
// corner sequences, and a randomized run against a queue-based reference model.
module tb_detect_channel_scheduler;

  logic       CP = 1'b0;
  logic       RST;

  // main instance: default pattern 1101, 8-bit counters
  logic       en, clr, hit_valid;
  logic [3:0] req, din, gnt;
  logic [1:0] clr_sel, rd_sel, hit_ch;
  logic [7:0] rd_cnt;

  // second instance: pattern 0001, 2-bit counters
  logic       en_b, clr_b, hit_valid_b;
  logic [3:0] req_b, din_b, gnt_b;
  logic [1:0] clr_sel_b, rd_sel_b, hit_ch_b;
  logic [1:0] rd_cnt_b;

  int total = 0;
  int bad   = 0;

  always #5 CP = ~CP;

  detect_channel_scheduler #(.NCH(4), .PLEN(4), .PATTERN(4'b1101), .CNT_W(8)) dut (
    .CP(CP), .RST(RST), .en(en), .req(req), .din(din), .gnt(gnt),
    .hit_valid(hit_valid), .hit_ch(hit_ch), .clr(clr), .clr_sel(clr_sel),
    .rd_sel(rd_sel), .rd_cnt(rd_cnt)
  );

  detect_channel_scheduler #(.NCH(4), .PLEN(4), .PATTERN(4'b0001), .CNT_W(2)) dut_b (
    .CP(CP), .RST(RST), .en(en_b), .req(req_b), .din(din_b), .gnt(gnt_b),
    .hit_valid(hit_valid_b), .hit_ch(hit_ch_b), .clr(clr_b), .clr_sel(clr_sel_b),
    .rd_sel(rd_sel_b), .rd_cnt(rd_cnt_b)
  );

  typedef struct {
    logic       rst_before;
    logic       en;
    logic [3:0] req;
    logic [3:0] din;
    logic [3:0] exp_gnt;
    logic       exp_hv;
    logic [1:0] exp_hc;
  } vec_t;

  vec_t vecs[$];

  function automatic void addVec(input logic rb, input logic e, input logic [3:0] r,
                                 input logic [3:0] d, input logic [3:0] eg,
                                 input logic hv, input logic [1:0] hc);
    vec_t v;
    v.rst_before = rb; v.en = e; v.req = r; v.din = d;
    v.exp_gnt = eg; v.exp_hv = hv; v.exp_hc = hc;
    vecs.push_back(v);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic e, input logic [3:0] r, input logic [3:0] d,
                               input logic c, input logic [1:0] cs);
    en = e; req = r; din = d; clr = c; clr_sel = cs;
  endtask

  task automatic tick();
    @(posedge CP);
    #1;
  endtask

  task automatic doReset();
    RST = 1'b1;
    applyStimulus(1'b0, 4'h0, 4'h0, 1'b0, 2'd0);
    req_b = 4'h0;
    @(negedge CP);
    RST = 1'b0;
    tick();
  endtask

  // gnt checked before the edge, registered outputs just after it
  task automatic cycleCheck(input string nm, input logic [3:0] eg, input logic ehv,
                            input logic [1:0] ehc);
    @(negedge CP);
    checkOutput({nm, ".gnt"}, gnt, eg);
    tick();
    checkOutput({nm, ".hit_valid"}, hit_valid, ehv);
    checkOutput({nm, ".hit_ch"}, hit_ch, ehc);
  endtask

  initial begin
    logic s1 [4];
    logic s2 [5];
    logic [3:0] r, d, g;
    int i1, i2, h1, h2, hother, first_hit, nhits_b;

    RST = 1'b1;
    applyStimulus(1'b1, 4'hF, 4'h0, 1'b0, 2'd0);
    rd_sel = 2'd0;
    en_b = 1'b1; req_b = 4'h0; din_b = 4'h0; clr_b = 1'b0; clr_sel_b = 2'd0; rd_sel_b = 2'd0;
    #2;
    checkOutput("reset.gnt", gnt, 4'h0);
    checkOutput("reset.hit_valid", hit_valid, 1'b0);
    checkOutput("reset.hit_ch", hit_ch, 2'd0);
    checkOutput("reset.rd_cnt", rd_cnt, 8'd0);
    @(negedge CP);
    RST = 1'b0;
    tick();

    // rotation with all requesting, en pause, then channel-0 overlapping stream
    addVec(1, 1, 4'hF, 4'h0, 4'b0001, 0, 0);
    addVec(0, 1, 4'hF, 4'h0, 4'b0010, 0, 0);
    addVec(0, 1, 4'hF, 4'h0, 4'b0100, 0, 0);
    addVec(0, 1, 4'hF, 4'h0, 4'b1000, 0, 0);
    addVec(0, 1, 4'hF, 4'h0, 4'b0001, 0, 0);
    addVec(0, 0, 4'hF, 4'h0, 4'b0000, 0, 0);
    addVec(0, 0, 4'hF, 4'h0, 4'b0000, 0, 0);
    addVec(0, 1, 4'hF, 4'h0, 4'b0010, 0, 0);
    addVec(1, 1, 4'h1, 4'h1, 4'b0001, 0, 0);
    addVec(0, 1, 4'h1, 4'h1, 4'b0001, 0, 0);
    addVec(0, 1, 4'h1, 4'h0, 4'b0001, 0, 0);
    addVec(0, 1, 4'h1, 4'h1, 4'b0001, 1, 0);
    addVec(0, 1, 4'h1, 4'h1, 4'b0001, 0, 0);
    addVec(0, 1, 4'h1, 4'h0, 4'b0001, 0, 0);
    addVec(0, 1, 4'h1, 4'h1, 4'b0001, 1, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst_before) doReset();
      applyStimulus(vecs[i].en, vecs[i].req, vecs[i].din, 1'b0, 2'd0);
      cycleCheck($sformatf("vec%0d", i), vecs[i].exp_gnt, vecs[i].exp_hv, vecs[i].exp_hc);
    end
    applyStimulus(1'b1, 4'h0, 4'h0, 1'b0, 2'd0);
    rd_sel = 2'd0;
    #1;
    checkOutput("ch0.rd_cnt", rd_cnt, 8'd2);

    // channels 1 and 2 interleaved, requesters honour the handshake
    doReset();
    s1 = '{1'b1, 1'b1, 1'b0, 1'b1};
    s2 = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    i1 = 0; i2 = 0; h1 = 0; h2 = 0; hother = 0; first_hit = -1;
    for (int cyc = 0; cyc < 30 && (i1 < 4 || i2 < 5); cyc++) begin
      r = 4'h0; d = 4'h0;
      if (i1 < 4) begin r[1] = 1'b1; d[1] = s1[i1]; end
      if (i2 < 5) begin r[2] = 1'b1; d[2] = s2[i2]; end
      applyStimulus(1'b1, r, d, 1'b0, 2'd0);
      @(negedge CP);
      g = gnt;
      tick();
      if (g[1]) i1++;
      if (g[2]) i2++;
      if (hit_valid) begin
        if (first_hit < 0) first_hit = int'(hit_ch);
        if (hit_ch == 2'd1) h1++;
        else if (hit_ch == 2'd2) h2++;
        else hother++;
      end
    end
    checkOutput("ilv.ch1_done", i1, 4);
    checkOutput("ilv.ch2_done", i2, 5);
    checkOutput("ilv.hits_ch1", h1, 1);
    checkOutput("ilv.hits_ch2", h2, 1);
    checkOutput("ilv.hits_other", hother, 0);
    checkOutput("ilv.first_hit", first_hit, 1);

    // clear collides with a grant to channel 2
    applyStimulus(1'b1, 4'b0100, 4'b0100, 1'b0, 2'd0); cycleCheck("clrA", 4'b0100, 0, 2);
    applyStimulus(1'b1, 4'b0100, 4'b0100, 1'b0, 2'd0); cycleCheck("clrB", 4'b0100, 0, 2);
    applyStimulus(1'b1, 4'b0100, 4'b0000, 1'b0, 2'd0); cycleCheck("clrC", 4'b0100, 0, 2);
    applyStimulus(1'b1, 4'b0010, 4'b0000, 1'b0, 2'd0); cycleCheck("clrD", 4'b0010, 0, 2);
    rd_sel = 2'd2;
    applyStimulus(1'b1, 4'b0110, 4'b0100, 1'b1, 2'd2); cycleCheck("clr.edge", 4'b0010, 0, 2);
    checkOutput("clr.ch2_cnt", rd_cnt, 8'd0);
    applyStimulus(1'b1, 4'b0100, 4'b0100, 1'b0, 2'd0); cycleCheck("clr.retry", 4'b0100, 0, 2);
    applyStimulus(1'b1, 4'b0100, 4'b0100, 1'b0, 2'd0); cycleCheck("clr.b2", 4'b0100, 0, 2);
    applyStimulus(1'b1, 4'b0100, 4'b0000, 1'b0, 2'd0); cycleCheck("clr.b3", 4'b0100, 0, 2);
    applyStimulus(1'b1, 4'b0100, 4'b0100, 1'b0, 2'd0); cycleCheck("clr.b4", 4'b0100, 1, 2);
    checkOutput("clr.ch2_cnt_after", rd_cnt, 8'd1);
    rd_sel = 2'd1;
    #1;
    checkOutput("clr.ch1_cnt_kept", rd_cnt, 8'd1);

    // asynchronous reset mid-cycle after channel 0 received 1,1,0
    rd_sel = 2'd2;
    applyStimulus(1'b1, 4'b0001, 4'b0001, 1'b0, 2'd0); cycleCheck("ar.b1", 4'b0001, 0, 2);
    applyStimulus(1'b1, 4'b0001, 4'b0001, 1'b0, 2'd0); cycleCheck("ar.b2", 4'b0001, 0, 2);
    applyStimulus(1'b1, 4'b0001, 4'b0000, 1'b0, 2'd0); cycleCheck("ar.b3", 4'b0001, 0, 2);
    applyStimulus(1'b1, 4'b0001, 4'b0001, 1'b0, 2'd0);
    @(negedge CP);
    checkOutput("ar.gnt_before", gnt, 4'b0001);
    #2;
    RST = 1'b1;
    #1;
    checkOutput("ar.gnt_in_reset", gnt, 4'h0);
    checkOutput("ar.hv_in_reset", hit_valid, 1'b0);
    checkOutput("ar.hc_in_reset", hit_ch, 2'd0);
    checkOutput("ar.cnt_in_reset", rd_cnt, 8'd0);
    @(negedge CP);
    RST = 1'b0;
    tick();
    checkOutput("ar.first_bit_no_hit", hit_valid, 1'b0);
    applyStimulus(1'b1, 4'b0001, 4'b0001, 1'b0, 2'd0); cycleCheck("ar.c2", 4'b0001, 0, 0);
    applyStimulus(1'b1, 4'b0001, 4'b0000, 1'b0, 2'd0); cycleCheck("ar.c3", 4'b0001, 0, 0);
    applyStimulus(1'b1, 4'b0001, 4'b0001, 1'b0, 2'd0); cycleCheck("ar.c4", 4'b0001, 1, 0);
    applyStimulus(1'b0, 4'h0, 4'h0, 1'b0, 2'd0);

    // pattern 0001: a single 1 right after reset must not match
    doReset();
    req_b = 4'b0001; din_b = 4'b0001; rd_sel_b = 2'd0;
    @(negedge CP);
    checkOutput("fill.gnt", gnt_b, 4'b0001);
    tick();
    checkOutput("fill.hit_valid", hit_valid_b, 1'b0);
    checkOutput("fill.rd_cnt", rd_cnt_b, 2'd0);

    // five matches on channel 3 with a 2-bit counter
    rd_sel_b = 2'd3;
    nhits_b = 0;
    for (int k = 0; k < 20; k++) begin
      req_b = 4'b1000;
      din_b = (k % 4 == 3) ? 4'b1000 : 4'b0000;
      tick();
      checkOutput($sformatf("sat.hv%0d", k), hit_valid_b, (k % 4 == 3));
      if (hit_valid_b) begin
        nhits_b++;
        checkOutput($sformatf("sat.hc%0d", k), hit_ch_b, 2'd3);
        checkOutput($sformatf("sat.cnt%0d", k), rd_cnt_b, (nhits_b > 3) ? 3 : nhits_b);
      end
    end
    req_b = 4'h0;
    checkOutput("sat.total_hits", nhits_b, 5);
    checkOutput("sat.rd_cnt", rd_cnt_b, 2'd3);

    // randomized run against a queue-based model
    doReset();
    begin
      logic       q [4][$];
      int         mcnt [4];
      logic       pend [4];
      logic       pdin [4];
      int         last_ptr, eg, cs, rs, j;
      logic [1:0] mhc;
      logic       e, c, ehv;
      logic [3:0] w;
      for (int i = 0; i < 4; i++) begin
        q[i].delete(); mcnt[i] = 0; pend[i] = 1'b0; pdin[i] = 1'b0;
      end
      last_ptr = 3;
      mhc = 2'd0;
      for (int cyc = 0; cyc < 400; cyc++) begin
        e  = ($urandom_range(9) != 0);
        c  = ($urandom_range(7) == 0);
        cs = $urandom_range(3);
        rs = $urandom_range(3);
        for (int i = 0; i < 4; i++) begin
          if (pend[i]) begin
            r[i] = 1'b1; d[i] = pdin[i];
          end else begin
            r[i] = ($urandom_range(1) == 1); d[i] = ($urandom_range(2) != 0);
          end
        end
        eg = -1;
        if (e) begin
          for (int k = 1; k <= 4; k++) begin
            j = (last_ptr + k) % 4;
            if (r[j] && !(c && cs == j)) begin
              eg = j;
              break;
            end
          end
        end
        applyStimulus(e, r, d, c, 2'(cs));
        rd_sel = 2'(rs);
        @(negedge CP);
        checkOutput($sformatf("rnd%0d.gnt", cyc), gnt, (eg >= 0) ? (32'd1 << eg) : 32'd0);
        tick();
        ehv = 1'b0;
        if (eg >= 0) begin
          q[eg].push_back(d[eg]);
          if (q[eg].size() > 4) void'(q[eg].pop_front());
          if (q[eg].size() == 4) begin
            w = {q[eg][0], q[eg][1], q[eg][2], q[eg][3]};
            if (w == 4'b1101) begin
              ehv = 1'b1;
              mhc = 2'(eg);
              if (mcnt[eg] < 255) mcnt[eg]++;
            end
          end
          last_ptr = eg;
        end
        if (c) begin
          q[cs].delete();
          mcnt[cs] = 0;
        end
        for (int i = 0; i < 4; i++) begin
          pend[i] = r[i] && (eg != i);
          pdin[i] = d[i];
        end
        checkOutput($sformatf("rnd%0d.hv", cyc), hit_valid, ehv);
        checkOutput($sformatf("rnd%0d.hc", cyc), hit_ch, mhc);
        checkOutput($sformatf("rnd%0d.cnt", cyc), rd_cnt, mcnt[rs]);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/detect_channel_scheduler.md
Name: detect_channel_scheduler

Overview:
- Shares one pattern-match engine between NCH serial bit-stream channels by time-multiplexing. Default pattern is 1101, with overlapping matches.
- A round-robin arbiter grants one requesting channel per cycle. The granted channel's saved context (bit history and fill count) is loaded, the new bit is evaluated, and the context is written back.
- Per-channel saturating hit counters are readable by the host.
- Sits between serial receivers and the status/host logic, replacing per-channel detector instances.

Parameters:
- NCH, 4, number of channels (2..16).
- PLEN, 4, pattern length in bits (2..8).
- PATTERN, 4'b1101, pattern to detect; MSB is the earliest-received bit.
- CNT_W, 8, width of each per-channel hit counter.

Ports:
- CP  input  1  clock, rising edge.
- RST  input  1  reset.
- en  input  1  scheduler enable; low means no grants.
- req  input  NCH  per-channel bit-available request.
- din  input  NCH  per-channel data bit, valid while req is high.
- gnt  output  NCH  one-hot grant, combinational; the bit is consumed at the edge where req[i]&gnt[i].
- hit_valid  output  1  registered one-cycle pulse: match completed on the bit consumed at the previous edge.
- hit_ch  output  clog2(NCH)  channel of that match.
- clr  input  1  clear-channel strobe.
- clr_sel  input  clog2(NCH)  channel to clear.
- rd_sel  input  clog2(NCH)  counter read select.
- rd_cnt  output  CNT_W  hit counter of channel rd_sel, combinational.

Behaviour:
- Reset: RST, asynchronous, active-high. While asserted:
  - gnt = 0, hit_valid = 0, hit_ch = 0.
  - All histories, fill counts and hit counters = 0.
  - Round-robin pointer = NCH-1, so channel 0 has first priority.
- Reset mid-stream discards all partial histories. The first match after release needs PLEN fresh bits on that channel.
- Per-channel context:
  - hist: PLEN-1 bits.
  - fill: saturates at PLEN-1.
  - cnt: CNT_W bits.
- Arbitration:
  - When en=1, gnt selects the first i with req[i]=1, searching from ptr+1 upward and wrapping modulo NCH.
  - gnt = 0 when en=0, when req = 0, or during RST.
  - ptr updates to the granted index only on a consuming edge. Otherwise it holds.
- Handshake: a requester holds req and din stable until it samples gnt[i]=1 at a rising edge. It may drop req or present the next bit on the following cycle.
- Evaluation on a consuming edge for channel g with bit b:
  - match = (fill == PLEN-1) && ({hist[g], b} == PATTERN).
  - hist[g] <= {hist[g][PLEN-3:0], b}; fill[g] increments and saturates.
  - hit_valid <= match; hit_ch <= g when match, otherwise holds.
  - On match, cnt[g] increments and saturates at all-ones (no wrap).
- No consuming edge: hit_valid <= 0.
- Latency: a match is visible on hit_valid exactly 1 cycle after the consuming edge, like a registered detector output.
- Overlap: history is not flushed on a match. With 1101, the stream 1101101 yields two hits.
- Clear:
  - On an edge with clr=1, hist, fill and cnt of channel clr_sel are zeroed.
  - If the same edge would also consume from clr_sel, clear wins: gnt[clr_sel] is forced low that cycle and the arbiter picks the next requester instead.
  - Clearing other channels does not disturb them.
- Throughput: one bit per cycle aggregate. With all req held high, each channel gets 1 bit every NCH cycles.
- rd_cnt reflects counter updates the cycle after the edge.

Test Plan:
- Channel 0 only, en=1, bits 1,1,0,1,1,0,1 on consecutive grants → hit_valid pulses 1 cycle after the 4th and 7th consumption, hit_ch=0; rd_sel=0 gives rd_cnt=2.
- req=4'b1111 held, en=1 from reset → gnt sequence 0001, 0010, 0100, 1000, 0001. en=0 for 2 cycles → gnt=0 and ptr holds; resuming grants the next channel in order.
- Channels 1 and 2 interleaved: ch1 sends 1,1,0,1 and ch2 sends 0,1,1,0,1 → exactly one hit each (hit_ch=1, then hit_ch=2), no cross-talk. Pattern 0001 after reset with only 1 bit sent → no hit (fill gating).
- CNT_W=2 override, 5 matches on ch3 → rd_cnt=3 (saturated), hit_valid still pulses on all 5.
- clr=1, clr_sel=2 on the same edge as req[2]=1 being granted, with req[1]=1 → gnt[1] wins, ch2 counter and history = 0, ch2 bit retried the next cycle.
- Assert RST asynchronously mid-cycle after ch0 has received 1,1,0 → gnt, hit_valid drop immediately. After release, sending 1 → no hit; 1,1,0,1 → hit.
